bkt_lvl_ctrl: RTL and testbench
===============================

BKT_LVL_CTRL -- requirements
Module: bkt_lvl_ctrl

Interface
REQ-001 Parameter NUM_LVLS, default 32: number of level-state entries in the chain.
REQ-002 Parameter WIDTH_LVL, default 16: level width.
REQ-003 Parameter WIDTH_BIN_ID, default 10: bin id width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start_find_i  in  1  request a backtrack-level search after a conflict.
REQ-007 conflict_max_lvl_i  in  WIDTH_LVL  highest level involved in the conflict.
REQ-008 cur_bin_i  in  WIDTH_BIN_ID  bin currently loaded in the engine.
REQ-009 findflag_last_i  in  2  findflag out of the last chain entry; 0 means no candidate level.
REQ-010 bkt_bin_vec_i  in  NUM_LVLS*WIDTH_BIN_ID  concatenated registered bkt_bin outputs of the chain.
REQ-011 bkt_lvl_vec_i  in  NUM_LVLS*WIDTH_LVL  concatenated registered bkt_lvl outputs of the chain.
REQ-012 max_lvl_o  out  WIDTH_LVL  search bound broadcast to every chain entry.
REQ-013 apply_bkt_o  out  1  one-cycle pulse telling the chain to flip or clear entries.
REQ-014 bkt_lvl_o  out  WIDTH_LVL  level to backtrack to.
REQ-015 bkt_bin_o  out  WIDTH_BIN_ID  bin that owns that decision.
REQ-016 bin_switch_o  out  1  bkt_bin_o differs from cur_bin_i as captured at start.
REQ-017 unsat_o  out  1  no un-backtracked level exists, so the formula is UNSAT.
REQ-018 busy_o  out  1  search in progress.
REQ-019 done_o  out  1  one-cycle pulse; all result outputs are valid in this cycle.

Function
REQ-020 FSM states: IDLE, SETTLE, REDUCE, APPLY, DONE.
REQ-021 FSM transitions:
- IDLE with start_find_i=1 -> SETTLE; capture conflict_max_lvl_i into max_lvl_o and cur_bin_i into an internal register.
- SETTLE -> REDUCE unconditionally; this one cycle lets the chain register its bkt outputs.
- REDUCE -> APPLY if findflag_last_i!=0; otherwise -> DONE with unsat_o<=1.
- APPLY -> DONE; DONE -> IDLE.
REQ-022 Result capture in REDUCE: bkt_lvl_o <= bitwise OR over all NUM_LVLS bkt_lvl fields; bkt_bin_o <= bitwise OR over all bkt_bin fields; bin_switch_o <= (OR'd bin != captured bin); unsat_o <= 0.
REQ-023 apply_bkt_o SHALL be 1 only in the APPLY state, for exactly one cycle.
REQ-024 done_o SHALL be 1 only in the DONE state; latency from start to done_o is 4 cycles (found) or 3 cycles (unsat).
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 max_lvl_o SHALL hold its captured value from SETTLE until the next accepted start, including through APPLY.
REQ-027 Result outputs SHALL hold their values after DONE until the next REDUCE.
REQ-028 start_find_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-029 In the unsat case, bkt_lvl_o and bkt_bin_o SHALL be 0 and bin_switch_o SHALL be 0.
REQ-030 A start request with conflict_max_lvl_i=0 SHALL be processed normally; the outcome depends only on the chain response.

Reset
REQ-031 Asserting rst low SHALL force IDLE and zero every output, at any time, including mid-search.
REQ-032 A search interrupted by reset SHALL NOT be resumed, and no apply_bkt_o SHALL be issued after reset release.

Structure
REQ-033 Shared sat-engine package SHALL hold the width defaults and the FSM state encoding.
REQ-034 Sub-module bkt_or_reduce, a parameterised combinational OR over the packed vectors, SHALL be instantiated once for the level vector and once for the bin vector.
REQ-035 All outputs SHALL be registered; there is no combinational path from input to output.

Verification
REQ-036 Start with max_lvl 5, chain entry 3 returning bkt_lvl 3 and bkt_bin 7, cur_bin 7 -> apply_bkt_o high at cycle 3, done_o at cycle 4, bkt_lvl_o=3, bkt_bin_o=7, bin_switch_o=0, unsat_o=0.
REQ-037 Same as REQ-036 but cur_bin 2 -> bin_switch_o=1.
REQ-038 findflag_last_i=0 -> no apply_bkt_o, done_o at cycle 3, unsat_o=1, bkt_lvl_o=0.
REQ-039 Second start_find_i pulse during SETTLE or APPLY -> ignored; exactly one done_o.
REQ-040 rst low during REDUCE -> all outputs 0 at once, no apply_bkt_o after release, and a fresh start completes normally.
REQ-041 Entry at index NUM_LVLS-1 returning bkt_lvl 31 and bkt_bin 1023 -> values reported intact, confirming the top slice is OR-reduced.

Source files
------------

// File: rtl/bkt_lvl_ctrl_pkg.sv
// Shared sat-engine definitions: width defaults and the
// state encoding of the backtrack-level controller.
package bkt_lvl_ctrl_pkg;

    localparam int DEF_NUM_LVLS     = 32;
    localparam int DEF_WIDTH_LVL    = 16;
    localparam int DEF_WIDTH_BIN_ID = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REDUCE = 3'd2,
        ST_APPLY  = 3'd3,
        ST_DONE   = 3'd4
    } bkt_state_t;

endpackage

// File: rtl/bkt_or_reduce.sv
// Bitwise OR of N packed W-bit fields; at most one chain
// entry is non-zero, so the OR acts as a one-hot select.
module bkt_or_reduce #(
    parameter int N = 32,
    parameter int W = 16
) (
    input  logic [N*W-1:0] i_vec,
    output logic [W-1:0]   o_red
);

    always_comb begin
        o_red = '0;
        for (int k = 0; k < N; k++) begin
            o_red = o_red | i_vec[k*W +: W];
        end
    end

endmodule

// File: rtl/bkt_lvl_ctrl.sv
// Backtrack-level controller: bounds the chain search,
// collects the winning level/bin and pulses apply/done.
module bkt_lvl_ctrl
    import bkt_lvl_ctrl_pkg::*;
#(
    parameter int NUM_LVLS     = DEF_NUM_LVLS,
    parameter int WIDTH_LVL    = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID = DEF_WIDTH_BIN_ID
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_find_i,
    input  logic [WIDTH_LVL-1:0]             conflict_max_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]          cur_bin_i,
    input  logic [1:0]                       findflag_last_i,
    input  logic [NUM_LVLS*WIDTH_BIN_ID-1:0] bkt_bin_vec_i,
    input  logic [NUM_LVLS*WIDTH_LVL-1:0]    bkt_lvl_vec_i,
    output logic [WIDTH_LVL-1:0]             max_lvl_o,
    output logic                             apply_bkt_o,
    output logic [WIDTH_LVL-1:0]             bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]          bkt_bin_o,
    output logic                             bin_switch_o,
    output logic                             unsat_o,
    output logic                             busy_o,
    output logic                             done_o
);

    bkt_state_t              r_state;
    logic [WIDTH_BIN_ID-1:0] r_cur_bin;
    logic [WIDTH_LVL-1:0]    w_or_lvl;
    logic [WIDTH_BIN_ID-1:0] w_or_bin;
    logic                    w_found;

    bkt_or_reduce #(
        .N (NUM_LVLS),
        .W (WIDTH_LVL)
    ) u_or_lvl (
        .i_vec (bkt_lvl_vec_i),
        .o_red (w_or_lvl)
    );

    bkt_or_reduce #(
        .N (NUM_LVLS),
        .W (WIDTH_BIN_ID)
    ) u_or_bin (
        .i_vec (bkt_bin_vec_i),
        .o_red (w_or_bin)
    );

    assign w_found = (findflag_last_i != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cur_bin    <= '0;
            max_lvl_o    <= '0;
            apply_bkt_o  <= 1'b0;
            bkt_lvl_o    <= '0;
            bkt_bin_o    <= '0;
            bin_switch_o <= 1'b0;
            unsat_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            apply_bkt_o <= 1'b0;
            done_o      <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_find_i) begin
                        r_state   <= ST_SETTLE;
                        max_lvl_o <= conflict_max_lvl_i;
                        r_cur_bin <= cur_bin_i;
                        busy_o    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_REDUCE;
                end
                ST_REDUCE: begin
                    // No candidate: report zeros, not stale chain data
                    if (w_found) begin
                        r_state      <= ST_APPLY;
                        apply_bkt_o  <= 1'b1;
                        bkt_lvl_o    <= w_or_lvl;
                        bkt_bin_o    <= w_or_bin;
                        bin_switch_o <= (w_or_bin != r_cur_bin);
                        unsat_o      <= 1'b0;
                    end else begin
                        r_state      <= ST_DONE;
                        done_o       <= 1'b1;
                        bkt_lvl_o    <= '0;
                        bkt_bin_o    <= '0;
                        bin_switch_o <= 1'b0;
                        unsat_o      <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_DONE;
                    done_o  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bkt_lvl_ctrl.sv
// Directed bench for bkt_lvl_ctrl: vector table plus
// hand-written reset and ignored-start sequences.
module tb_bkt_lvl_ctrl;

    localparam int NL = 32;
    localparam int WL = 16;
    localparam int WB = 10;

    logic            clk;
    logic            rst;
    logic            start_find_i;
    logic [WL-1:0]   conflict_max_lvl_i;
    logic [WB-1:0]   cur_bin_i;
    logic [1:0]      findflag_last_i;
    logic [NL*WB-1:0] bkt_bin_vec_i;
    logic [NL*WL-1:0] bkt_lvl_vec_i;
    logic [WL-1:0]   max_lvl_o;
    logic            apply_bkt_o;
    logic [WL-1:0]   bkt_lvl_o;
    logic [WB-1:0]   bkt_bin_o;
    logic            bin_switch_o;
    logic            unsat_o;
    logic            busy_o;
    logic            done_o;

    bkt_lvl_ctrl #(
        .NUM_LVLS     (NL),
        .WIDTH_LVL    (WL),
        .WIDTH_BIN_ID (WB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_find_i       (start_find_i),
        .conflict_max_lvl_i (conflict_max_lvl_i),
        .cur_bin_i          (cur_bin_i),
        .findflag_last_i    (findflag_last_i),
        .bkt_bin_vec_i      (bkt_bin_vec_i),
        .bkt_lvl_vec_i      (bkt_lvl_vec_i),
        .max_lvl_o          (max_lvl_o),
        .apply_bkt_o        (apply_bkt_o),
        .bkt_lvl_o          (bkt_lvl_o),
        .bkt_bin_o          (bkt_bin_o),
        .bin_switch_o       (bin_switch_o),
        .unsat_o            (unsat_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WL-1:0] ml;
        logic [WB-1:0] cb;
        logic [1:0]    ff;
        int            idx;
        logic [WL-1:0] lvl;
        logic [WB-1:0] bin;
        logic [8:0]    extra;
        logic          found;
        logic [WL-1:0] e_lvl;
        logic [WB-1:0] e_bin;
        logic          e_sw;
    } vec_t;

    vec_t tv[7];

    int n_cmp;
    int n_bad;
    int apply_cyc, done_cyc, n_apply, n_done;
    logic [WL-1:0] d_lvl, d_max;
    logic [WB-1:0] d_bin;
    logic          d_sw, d_unsat, d_busy;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_chain(input int idx, input logic [WL-1:0] lvl,
                              input logic [WB-1:0] bin);
        bkt_lvl_vec_i = '0;
        bkt_bin_vec_i = '0;
        bkt_lvl_vec_i[idx*WL +: WL] = lvl;
        bkt_bin_vec_i[idx*WB +: WB] = bin;
    endtask

    // extra[c] drives start_find_i in the interval after edge c
    task automatic run_search(input logic [WL-1:0] ml,
                              input logic [WB-1:0] cb,
                              input logic [1:0] ff,
                              input logic [8:0] extra);
        @(negedge clk);
        conflict_max_lvl_i = ml;
        cur_bin_i          = cb;
        findflag_last_i    = ff;
        start_find_i       = 1'b1;
        apply_cyc = 0; done_cyc = 0; n_apply = 0; n_done = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start_find_i = extra[c];
            if (apply_bkt_o) begin
                n_apply++;
                apply_cyc = c;
            end
            if (done_o) begin
                n_done++;
                done_cyc = c;
                d_lvl = bkt_lvl_o;
                d_bin = bkt_bin_o;
                d_sw = bin_switch_o;
                d_unsat = unsat_o;
                d_busy = busy_o;
                d_max = max_lvl_o;
            end
        end
        start_find_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //        ml       cb       ff idx lvl       bin      extra  fnd e_lvl    e_bin    sw
        tv[0] = '{16'd5,   10'd7,   2'd1, 3, 16'd3,    10'd7,   9'h000, 1, 16'd3,    10'd7,   0};
        tv[1] = '{16'd5,   10'd2,   2'd1, 3, 16'd3,    10'd7,   9'h00A, 1, 16'd3,    10'd7,   1};
        tv[2] = '{16'd5,   10'd7,   2'd0, 3, 16'd0,    10'd0,   9'h000, 0, 16'd0,    10'd0,   0};
        tv[3] = '{16'd0,   10'd0,   2'd2, 31, 16'd31,  10'd1023, 9'h000, 1, 16'd31,  10'd1023, 1};
        tv[4] = '{16'hFFFF, 10'd1023, 2'd3, 0, 16'h8001, 10'h200, 9'h000, 1, 16'h8001, 10'h200, 1};
        tv[5] = '{16'd9,   10'd5,   2'd0, 10, 16'd4,   10'd5,   9'h00A, 0, 16'd0,    10'd0,   0};
        tv[6] = '{16'd12,  10'd300, 2'd1, 17, 16'd11,  10'd300, 9'h000, 1, 16'd11,   10'd300, 0};

        rst = 1'b0;
        start_find_i = 1'b0;
        conflict_max_lvl_i = '0;
        cur_bin_i = '0;
        findflag_last_i = '0;
        bkt_lvl_vec_i = '0;
        bkt_bin_vec_i = '0;
        #7;
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_apply", 32'(apply_bkt_o), 32'd0);
        chk("rst_max",   32'(max_lvl_o), 32'd0);
        chk("rst_lvl",   32'(bkt_lvl_o), 32'd0);
        chk("rst_unsat", 32'(unsat_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load_chain(tv[i].idx, tv[i].lvl, tv[i].bin);
            run_search(tv[i].ml, tv[i].cb, tv[i].ff, tv[i].extra);
            chk($sformatf("v%0d_n_apply", i), 32'(n_apply),
                tv[i].found ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_apply_cyc", i), 32'(apply_cyc),
                tv[i].found ? 32'd3 : 32'd0);
            chk($sformatf("v%0d_n_done", i), 32'(n_done), 32'd1);
            chk($sformatf("v%0d_done_cyc", i), 32'(done_cyc),
                tv[i].found ? 32'd4 : 32'd3);
            chk($sformatf("v%0d_lvl", i), 32'(d_lvl), 32'(tv[i].e_lvl));
            chk($sformatf("v%0d_bin", i), 32'(d_bin), 32'(tv[i].e_bin));
            chk($sformatf("v%0d_sw", i), 32'(d_sw), 32'(tv[i].e_sw));
            chk($sformatf("v%0d_unsat", i), 32'(d_unsat),
                tv[i].found ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_busy_at_done", i), 32'(d_busy), 32'd1);
            chk($sformatf("v%0d_max_at_done", i), 32'(d_max), 32'(tv[i].ml));
            // results and bound must persist while idle
            chk($sformatf("v%0d_idle_busy", i), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_hold_lvl", i), 32'(bkt_lvl_o), 32'(tv[i].e_lvl));
            chk($sformatf("v%0d_hold_bin", i), 32'(bkt_bin_o), 32'(tv[i].e_bin));
            chk($sformatf("v%0d_hold_unsat", i), 32'(unsat_o),
                tv[i].found ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_hold_max", i), 32'(max_lvl_o), 32'(tv[i].ml));
        end

        // reset asserted while the FSM sits in REDUCE
        load_chain(3, 16'd3, 10'd7);
        @(negedge clk);
        conflict_max_lvl_i = 16'd5;
        cur_bin_i = 10'd2;
        findflag_last_i = 2'd1;
        start_find_i = 1'b1;
        @(posedge clk);
        #1;
        start_find_i = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy_o), 32'd0);
        chk("mid_rst_apply", 32'(apply_bkt_o), 32'd0);
        chk("mid_rst_done",  32'(done_o), 32'd0);
        chk("mid_rst_max",   32'(max_lvl_o), 32'd0);
        chk("mid_rst_lvl",   32'(bkt_lvl_o), 32'd0);
        chk("mid_rst_bin",   32'(bkt_bin_o), 32'd0);
        chk("mid_rst_sw",    32'(bin_switch_o), 32'd0);
        chk("mid_rst_unsat", 32'(unsat_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_apply = 0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (apply_bkt_o) n_apply++;
            if (done_o || busy_o) n_done++;
        end
        chk("post_rst_apply", 32'(n_apply), 32'd0);
        chk("post_rst_activity", 32'(n_done), 32'd0);

        run_search(16'd5, 10'd7, 2'd1, 9'h000);
        chk("fresh_apply_cyc", 32'(apply_cyc), 32'd3);
        chk("fresh_done_cyc", 32'(done_cyc), 32'd4);
        chk("fresh_n_done", 32'(n_done), 32'd1);
        chk("fresh_lvl", 32'(d_lvl), 32'd3);
        chk("fresh_bin", 32'(d_bin), 32'd7);
        chk("fresh_sw", 32'(d_sw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
